uart_rx_frame: RTL

//  UART receive-path deserializer. The receive-side counterpart of the TX parity generator/serializer.

---
 rtl/uart_rx_frame.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/uart_rx_frame.sv
// UART receive deserializer: start detect, LSB-first data,
// optional parity check, stop check, one-cycle result strobes.
module uart_rx_frame #(
  parameter int DATA_WIDTH = 8,
  parameter int OVERSAMPLE = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_in,
  input  logic                  par_en,
  input  logic                  par_type,
  output logic [DATA_WIDTH-1:0] p_data,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err,
  output logic                  rx_busy
);

  localparam int EW = $clog2(OVERSAMPLE);
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP
  } state_t;

  state_t                state, state_nx;
  logic                  sync1, rxs;
  logic [EW-1:0]         edge_cnt, edge_nx;
  logic [BW-1:0]         bit_cnt, bit_nx;
  logic [2:0]            samp;
  logic [DATA_WIDTH-1:0] shreg, shreg_nx;
  logic [DATA_WIDTH-1:0] pdata_nx;
  logic                  pe_q, pe_nx;
  logic                  pt_q, pt_nx;
  logic                  bad, bad_nx;
  logic                  dv_nx, perr_nx, serr_nx;
  logic                  bit_end, bit_val, exp_par, in_win;

  assign bit_end = (edge_cnt == EW'(OVERSAMPLE - 1));
  assign in_win  = (edge_cnt >= EW'(OVERSAMPLE/2 - 1)) &&
                   (edge_cnt <= EW'(OVERSAMPLE/2 + 1));
  assign bit_val = (samp[0] & samp[1]) | (samp[1] & samp[2]) |
                   (samp[0] & samp[2]);
  // Odd parity flips the even-parity expectation.
  assign exp_par = (^shreg) ^ pt_q;
  assign rx_busy = (state != IDLE);

  always_comb begin
    state_nx = state;
    edge_nx  = edge_cnt;
    bit_nx   = bit_cnt;
    shreg_nx = shreg;
    pdata_nx = p_data;
    pe_nx    = pe_q;
    pt_nx    = pt_q;
    bad_nx   = bad;
    dv_nx    = 1'b0;
    perr_nx  = 1'b0;
    serr_nx  = 1'b0;
    if (state != IDLE)
      edge_nx = bit_end ? '0 : EW'(edge_cnt + 1'b1);
    unique case (state)
      IDLE: begin
        if (!rxs) begin
          state_nx = START;
          edge_nx  = EW'(1);
          bit_nx   = '0;
          pe_nx    = par_en;
          pt_nx    = par_type;
          bad_nx   = 1'b0;
        end
      end
      START: begin
        if (bit_end)
          state_nx = bit_val ? IDLE : DATA;
      end
      DATA: begin
        if (bit_end) begin
          shreg_nx = {bit_val, shreg[DATA_WIDTH-1:1]};
          if (bit_cnt == BW'(DATA_WIDTH - 1)) begin
            bit_nx   = '0;
            state_nx = pe_q ? PARITY : STOP;
          end else begin
            bit_nx = BW'(bit_cnt + 1'b1);
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_nx = STOP;
          if (bit_val != exp_par) begin
            perr_nx = 1'b1;
            bad_nx  = 1'b1;
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          state_nx = IDLE;
          if (!bit_val) begin
            serr_nx = 1'b1;
          end else if (!bad) begin
            dv_nx    = 1'b1;
            pdata_nx = shreg;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1      <= 1'b1;
      rxs        <= 1'b1;
      state      <= IDLE;
      edge_cnt   <= '0;
      bit_cnt    <= '0;
      samp       <= '0;
      shreg      <= '0;
      p_data     <= '0;
      pe_q       <= 1'b0;
      pt_q       <= 1'b0;
      bad        <= 1'b0;
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
    end else begin
      sync1      <= rx_in;
      rxs        <= sync1;
      state      <= state_nx;
      edge_cnt   <= edge_nx;
      bit_cnt    <= bit_nx;
      shreg      <= shreg_nx;
      p_data     <= pdata_nx;
      pe_q       <= pe_nx;
      pt_q       <= pt_nx;
      bad        <= bad_nx;
      data_valid <= dv_nx;
      par_err    <= perr_nx;
      stp_err    <= serr_nx;
      if (state != IDLE && in_win)
        samp <= {samp[1:0], rxs};
    end
  end

endmodule
